// File: rtl/display_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : display_scan_ctrl
// Description : Time-multiplexed scan controller for a 4-digit seven-segment
//               display. It cycles the digits through SHOW and optional BLANK
//               phases, and it supports leading-zero blanking. A new value is
//               committed only at a frame boundary, so a frame never mixes
//               old and new digits.
// Ports       : clk        - system clock, rising edge
//               reset      - asynchronous active-high reset
//               en         - scan enable (0 = idle, all digits dark)
//               load       - one-cycle request to accept value
//               value      - four BCD nibbles, [3:0] = rightmost digit
//               lz_blank   - 1 = suppress leading zeros
//               data       - nibble to the shared decoder (4'hF = dark)
//               an         - active-low digit anodes
//               digit      - index of the digit being scanned
//               frame_tick - pulse on wrap from digit 3 to digit 0
//               load_ack   - pulse when a pending value is committed
// Revision    : 1.0 - initial release
// ============================================================================
module display_scan_ctrl #(
    parameter int DIV   = 50000,
    parameter int BLANK = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic        load,
    input  logic [15:0] value,
    input  logic        lz_blank,
    output logic [3:0]  data,
    output logic [3:0]  an,
    output logic [1:0]  digit,
    output logic        frame_tick,
    output logic        load_ack
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHOW  = 2'd1;
    localparam logic [1:0] S_BLANK = 2'd2;

    localparam int C_MAXC = (DIV > BLANK) ? DIV : BLANK;
    localparam int C_CW   = (C_MAXC > 1) ? $clog2(C_MAXC) : 1;

    localparam logic [C_CW-1:0] C_DIV_LAST   = C_CW'(DIV - 1);
    localparam logic [C_CW-1:0] C_BLANK_LAST = (BLANK > 0) ? C_CW'(BLANK - 1) : '0;

    logic [1:0]      state_q, state_d;
    logic [C_CW-1:0] cnt_q, cnt_d;
    logic [1:0]      digit_q, digit_d;
    logic [15:0]     disp_q, disp_d;
    logic [15:0]     pend_val_q, pend_val_d;
    logic            pend_q, pend_d;
    logic [3:0]      data_q, data_d;
    logic [3:0]      an_q, an_d;
    logic            tick_q, tick_d;
    logic            ack_q, ack_d;

    logic            enter_d0;   // this edge enters SHOW on digit 0
    logic            wrap;       // ...and it comes from digit 3, not from IDLE
    logic            lz_dark;
    logic            lit;

    // Next-state and scan sequencing
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + C_CW'(1);
        digit_d  = digit_q;
        enter_d0 = 1'b0;
        wrap     = 1'b0;

        if (!en) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            digit_d = 2'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d  = S_SHOW;
                    cnt_d    = '0;
                    digit_d  = 2'd0;
                    enter_d0 = 1'b1;
                end
                S_SHOW: begin
                    if (cnt_q == C_DIV_LAST) begin
                        cnt_d = '0;
                        if (BLANK == 0) begin
                            // No anti-ghosting gap: step straight to next digit
                            digit_d = digit_q + 2'd1;
                            if (digit_q == 2'd3) begin
                                enter_d0 = 1'b1;
                                wrap     = 1'b1;
                            end
                        end else begin
                            state_d = S_BLANK;
                        end
                    end
                end
                S_BLANK: begin
                    if (cnt_q == C_BLANK_LAST) begin
                        state_d = S_SHOW;
                        cnt_d   = '0;
                        digit_d = digit_q + 2'd1;
                        if (digit_q == 2'd3) begin
                            enter_d0 = 1'b1;
                            wrap     = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    digit_d = 2'd0;
                end
            endcase
        end
    end

    // Value capture and frame-aligned commit. A load landing on the commit
    // edge bypasses the pending register, so it gets only one acknowledge.
    always_comb begin
        disp_d     = disp_q;
        pend_val_d = pend_val_q;
        pend_d     = pend_q;
        ack_d      = 1'b0;

        if (enter_d0) begin
            if (load) begin
                disp_d = value;
            end else if (pend_q) begin
                disp_d = pend_val_q;
            end
            ack_d  = load | pend_q;
            pend_d = 1'b0;
        end else if (load) begin
            pend_val_d = value;
            pend_d     = 1'b1;
        end
    end

    // Registered outputs derived from the next state. This keeps them aligned
    // with the state register on the same edge.
    always_comb begin
        lz_dark = 1'b0;
        if (lz_blank) begin
            case (digit_d)
                2'd1:    lz_dark = (disp_d[15:4]  == 12'h000);
                2'd2:    lz_dark = (disp_d[15:8]  == 8'h00);
                2'd3:    lz_dark = (disp_d[15:12] == 4'h0);
                default: lz_dark = 1'b0;
            endcase
        end
        lit    = (state_d == S_SHOW) && !lz_dark;
        an_d   = lit ? ~(4'b0001 << digit_d) : 4'hF;
        data_d = lit ? disp_d[{digit_d, 2'b00} +: 4] : 4'hF;
        tick_d = wrap;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            digit_q    <= 2'd0;
            disp_q     <= 16'h0000;
            pend_val_q <= 16'h0000;
            pend_q     <= 1'b0;
            data_q     <= 4'hF;
            an_q       <= 4'hF;
            tick_q     <= 1'b0;
            ack_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            digit_q    <= digit_d;
            disp_q     <= disp_d;
            pend_val_q <= pend_val_d;
            pend_q     <= pend_d;
            data_q     <= data_d;
            an_q       <= an_d;
            tick_q     <= tick_d;
            ack_q      <= ack_d;
        end
    end

    assign data       = data_q;
    assign an         = an_q;
    assign digit      = digit_q;
    assign frame_tick = tick_q;
    assign load_ack   = ack_q;

endmodule
`default_nettype wire

// File: tb/tb_display_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_display_scan_ctrl
// Description : Scoreboard bench for display_scan_ctrl (DIV=4, BLANK=2).
//               A frame-position reference model predicts the outputs after
//               every clock edge and queues them. A separate monitor pops
//               each prediction and compares it with the design outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_display_scan_ctrl;

    localparam int DIV   = 4;
    localparam int BLANK = 2;
    localparam int SLOT  = DIV + BLANK;
    localparam int FRAME = 4 * SLOT;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        en = 1'b0;
    logic        load = 1'b0;
    logic [15:0] value = 16'h0000;
    logic        lz_blank = 1'b0;
    logic [3:0]  data;
    logic [3:0]  an;
    logic [1:0]  digit;
    logic        frame_tick;
    logic        load_ack;

    int chk_cnt  = 0;
    int pass_cnt = 0;
    int cyc      = 0;

    logic [11:0] exp_q[$];

    display_scan_ctrl #(.DIV(DIV), .BLANK(BLANK)) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .load       (load),
        .value      (value),
        .lz_blank   (lz_blank),
        .data       (data),
        .an         (an),
        .digit      (digit),
        .frame_tick (frame_tick),
        .load_ack   (load_ack)
    );

    always #5 clk = ~clk;

    // Reference model: the scan is a position 0..FRAME-1 inside a frame.
    // Each digit owns a SLOT-cycle window. The first DIV cycles are lit.
    initial begin : model
        bit          m_scan;
        int          m_pos;
        logic [15:0] m_disp, m_pend;
        bit          m_pf, commit, ft, ack, dark;
        int          dg;
        logic [3:0]  e_an, e_data;
        m_scan = 0; m_pos = 0; m_disp = '0; m_pend = '0; m_pf = 0;
        forever begin
            @(posedge clk);
            cyc++;
            if (reset) begin
                m_scan = 0; m_pos = 0; m_disp = '0; m_pend = '0; m_pf = 0;
                exp_q.push_back({4'hF, 4'hF, 2'd0, 1'b0, 1'b0});
            end else if (!en) begin
                m_scan = 0;
                if (load) begin m_pend = value; m_pf = 1; end
                exp_q.push_back({4'hF, 4'hF, 2'd0, 1'b0, 1'b0});
            end else begin
                ft = 0; ack = 0; commit = 0;
                if (!m_scan) begin
                    m_scan = 1; m_pos = 0; commit = 1;
                end else begin
                    m_pos = (m_pos + 1) % FRAME;
                    if (m_pos == 0) begin commit = 1; ft = 1; end
                end
                if (commit) begin
                    if (load)      begin m_disp = value;  ack = 1; end
                    else if (m_pf) begin m_disp = m_pend; ack = 1; end
                    m_pf = 0;
                end else if (load) begin
                    m_pend = value; m_pf = 1;
                end
                dg   = m_pos / SLOT;
                dark = ((m_pos % SLOT) >= DIV) ||
                       (lz_blank && dg > 0 && (m_disp >> (4 * dg)) == 16'h0);
                e_an   = dark ? 4'hF : ~(4'b0001 << dg);
                e_data = dark ? 4'hF : 4'((m_disp >> (4 * dg)) & 16'hF);
                exp_q.push_back({e_an, e_data, 2'(dg), ft, ack});
            end
        end
    end

    // Monitor: compare every post-edge output against the queued prediction
    initial begin : monitor
        logic [11:0] e, g;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                g = {an, data, digit, frame_tick, load_ack};
                chk_cnt++;
                if (g !== e)
                    $display("FAIL outputs cyc=%0d got an=%b data=%h digit=%0d tick=%b ack=%b required an=%b data=%h digit=%0d tick=%b ack=%b",
                             cyc, g[11:8], g[7:4], g[3:2], g[1], g[0],
                             e[11:8], e[7:4], e[3:2], e[1], e[0]);
                else
                    pass_cnt++;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_load(input logic [15:0] v);
        load  = 1'b1;
        value = v;
        step(1);
        load  = 1'b0;
    endtask

    // Wait for a frame boundary. An expired bound is counted as a failed check.
    task automatic wait_tick;
        int n;
        n = 0;
        @(negedge clk);
        while (!frame_tick && n < 4 * FRAME) begin
            @(negedge clk);
            n++;
        end
        if (!frame_tick) begin
            chk_cnt++;
            $display("FAIL frame_tick_timeout got none within %0d cycles required one", n);
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] rand_val();
        logic [15:0] v;
        for (int i = 0; i < 4; i++)
            v[4*i +: 4] = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
        return v;
    endfunction

    initial begin : stim
        step(3);
        @(negedge clk); #2 reset = 1'b0;
        step(2);

        // Value loaded while idle, then scan started
        do_load(16'h1234);
        step(2);
        en = 1'b1;
        step(2 * FRAME + 5);

        // Leading-zero blanking
        lz_blank = 1'b1;
        do_load(16'h0070);
        step(2 * FRAME);
        do_load(16'h0000);
        step(2 * FRAME);
        lz_blank = 1'b0;

        // Two loads during digit 2 SHOW: only the last lands, at the next frame
        do_load(16'h1234);
        wait_tick();
        wait_tick();
        step(2 * SLOT);
        do_load(16'h5678);
        do_load(16'h9ABC);
        step(2 * FRAME);

        // Enable dropped mid digit 1, then restored
        wait_tick();
        step(SLOT + 1);
        en = 1'b0;
        step(3);
        en = 1'b1;
        step(FRAME + 4);

        // Asynchronous reset mid digit 2 SHOW
        wait_tick();
        step(2 * SLOT);
        @(negedge clk); #2 reset = 1'b1;
        #1;
        chk_cnt++;
        if (an !== 4'hF) $display("FAIL async_reset_an got %b required 1111", an);
        else pass_cnt++;
        chk_cnt++;
        if (data !== 4'hF) $display("FAIL async_reset_data got %h required f", data);
        else pass_cnt++;
        step(2);
        @(negedge clk); #2 reset = 1'b0;
        step(FRAME + 4);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            en    = ($urandom_range(0, 39) != 0);
            load  = ($urandom_range(0, 7) == 0);
            value = rand_val();
            if ($urandom_range(0, 99) == 0) lz_blank = ~lz_blank;
            step(1);
        end
        load = 1'b0;
        step(3);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/display_scan_ctrl.md
DISPLAY_SCAN_CTRL -- requirements
Module: display_scan_ctrl

Interface
REQ-001 Parameter: DIV, 50000, clock cycles each digit is lit (SHOW phase); legal range >= 2.
REQ-002 Parameter: BLANK, 16, anode-off cycles after each SHOW phase (anti-ghosting); 0 omits the BLANK phase entirely.
REQ-003 Port: clk  input  1  system clock; all state changes on its rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-high reset.
REQ-005 Port: en  input  1  scan enable; 0 stops the scan and turns all digits dark.
REQ-006 Port: load  input  1  single-cycle request to accept value.
REQ-007 Port: value  input  16  four BCD nibbles; [3:0] is digit 0 (rightmost), [15:12] is digit 3.
REQ-008 Port: lz_blank  input  1  1 = suppress leading zeros.
REQ-009 Port: data  output  4  nibble for the shared sevensegment decoder; 4'hF = dark (decoder default).
REQ-010 Port: an  output  4  digit anodes, active-low; at most one bit low.
REQ-011 Port: digit  output  2  index of the digit currently scanned.
REQ-012 Port: frame_tick  output  1  one-cycle pulse at each wrap from digit 3 back to digit 0.
REQ-013 Port: load_ack  output  1  one-cycle pulse when a pending value is committed to the display.

Function
REQ-014 The FSM SHALL have states IDLE, SHOW and BLANK; all outputs SHALL be registered and SHALL change on the same edge as the state.
REQ-015 IDLE: an=4'b1111 and data=4'hF; when en=1, the FSM enters SHOW with digit=0 on the next edge.
REQ-016 SHOW: an[digit]=0 and data=the display nibble for that digit for exactly DIV cycles, then the FSM enters BLANK (or the next SHOW if BLANK=0).
REQ-017 BLANK: an=4'b1111 and data=4'hF for exactly BLANK cycles, then the FSM enters SHOW with digit+1 (mod 4).
REQ-018 Digit order SHALL be 0,1,2,3,0,...; frame_tick SHALL pulse on the edge that enters SHOW with digit=0 from digit 3; frame length is 4*(DIV+BLANK) cycles.
REQ-019 load=1 SHALL capture value into a pending register and set the pending flag; a second load before commit SHALL overwrite it (last wins).
REQ-020 Commit SHALL occur only on an edge entering SHOW with digit=0 (from IDLE or by wrap): pending value goes to the display register, pending clears, load_ack pulses once.
REQ-021 If load=1 in the commit cycle, that cycle's value SHALL be committed directly with a single load_ack.
REQ-022 A frame SHALL never mix old and new values (no tearing).
REQ-023 Leading-zero blanking (lz_blank=1): digit k (k>=1) SHALL be dark (an=1111, data=F) during its SHOW when its nibble and all higher nibbles are 0; digit 0 SHALL never be blanked; SHOW timing SHALL be unchanged.
REQ-024 Nibbles 10-15 SHALL pass through unchanged (the decoder renders them dark).
REQ-025 en=0 in any state SHALL force IDLE on the next edge and clear the cycle counter and digit; the pending and display registers SHALL be kept, and load SHALL remain accepted while idle.
REQ-026 The cycle counter SHALL be sized for max(DIV,BLANK) and SHALL reload on every state change.

Reset
REQ-027 reset=1 SHALL immediately force: state=IDLE, an=4'b1111, data=4'hF, digit=0, frame_tick=0, load_ack=0, counter=0, display register=16'h0000, pending value=0, pending flag=0.
REQ-028 After reset deasserts, scanning SHALL begin only once en=1, per REQ-015.

Verification (DIV=4, BLANK=2)
REQ-029 Reset, load 16'h1234 while idle, then en=1 -> load_ack once; SHOW d0 (data=4, an=1110) for 4 cycles, then 2 dark cycles, then d1=3 an=1101, d2=2 an=1011, d3=1 an=0111; frame_tick every 24 cycles.
REQ-030 lz_blank=1 with value 16'h0070 -> d3 and d2 dark through their SHOW windows; d1 data=7 an=1101; d0 data=0 an=1110.
REQ-031 lz_blank=1 with value 16'h0000 -> only d0 lit (data=0); the other three digits are dark.
REQ-032 Frame showing 1234; at d2 SHOW, load 5678 then 9ABC -> d2/d3 still show 2/1; next frame shows C,B,A,9; exactly one load_ack, on the edge of frame_tick.
REQ-033 reset pulse mid d2 SHOW, asynchronous to clk -> an=1111 and data=F before the next edge; after release with en=1, the scan restarts at d0 with display value 0000.
REQ-034 en=0 mid d1 SHOW -> an=1111 on the next edge; en=1 again -> restart at d0 with the full 4-cycle SHOW and the display value retained.
